// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Owns the fetch PC, issues word
// reads to a 1-cycle-latency instruction memory, buffers returned words with
// their PCs in a small FIFO and hands them to decode over valid/ready.
// DEPTH must be a power of two and at least 2 so the pointers wrap for free.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [31:0]                instr_out,
  output logic [31:0]                pc_out,
  output logic [31:0]                pc_plus4_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   instrMem_q [DEPTH];
  logic [31:0]   pcMem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflightPc_q, inflightPc_d;
  logic          drop_q, drop_d;

  logic [CW:0]   credit;
  logic          issue;
  logic          push;
  logic          pop;
  logic          headValid;

  // Next-state logic: credit-based issue, response push, head pop, redirect flush.
  always_comb begin
    fetchPc_d    = fetchPc_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    count_d      = count_q;
    inflight_d   = 1'b0;
    inflightPc_d = inflightPc_q;
    drop_d       = 1'b0;

    headValid = (count_q != '0);
    credit    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue     = rst & ~redirect & (credit < DEPTH_W);
    push      = inflight_q & ~drop_q & ~redirect;
    pop       = headValid & ready_in;

    if (redirect) begin
      count_d   = '0;
      rdPtr_d   = wrPtr_q;
      fetchPc_d = {redirect_pc[31:2], 2'b00};
      drop_d    = inflight_q;
    end else begin
      if (issue) begin
        inflight_d   = 1'b1;
        inflightPc_d = fetchPc_q;
        fetchPc_d    = fetchPc_q + 32'd4;
      end
      if (push) begin
        wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc_q    <= RESET_PC;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      fetchPc_q    <= fetchPc_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      drop_q       <= drop_d;
    end
  end

  // Queue storage; contents are only meaningful below count so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem_q[wrPtr_q] <= imem_rdata;
      pcMem_q[wrPtr_q]    <= inflightPc_q;
    end
  end

  // Head presentation: zeros (a nop at PC 0) whenever the queue is empty.
  always_comb begin
    imem_req     = issue;
    imem_addr    = fetchPc_q;
    valid_out    = headValid;
    count        = count_q;
    instr_out    = '0;
    pc_out       = '0;
    pc_plus4_out = '0;
    if (headValid) begin
      instr_out    = instrMem_q[rdPtr_q];
      pc_out       = pcMem_q[rdPtr_q];
      pc_plus4_out = pcMem_q[rdPtr_q] + 32'd4;
    end
  end

endmodule
